// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Holds one instruction, waits for the data-SRAM response when EX issued a
// memory request, aligns/extends load data and hands the result to WB.
// Responses that belong to instructions killed by a flush are dropped.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ex_mem_valid,
  input  logic [237:0] ex_mem_bus,
  output logic         mem_allowin,
  input  logic         wb_allowin,
  output logic         mem_wb_valid,
  output logic [231:0] mem_wb_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [38:0]  mem_id_bus,
  output logic         mem_flush_hint,
  input  logic         wb_ex,
  input  logic         ertn_flush
);

  // One-hot load type, MSB first as EX packs it.
  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
  } ld_op_t;

  // Field view of the EX->MEM bus; first member is the MSB.
  typedef struct packed {
    ld_op_t      ld_op;
    logic        mem_req;
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall_ex;
    logic [31:0] wrong_addr;
    logic        ex_id;
    logic [8:0]  esubcode;
    logic [5:0]  ecode;
  } ex_bus_t;

  // State
  logic        mem_valid_q, mem_valid_d;
  ex_bus_t     bus_q, bus_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        discard_q, discard_d;

  // Combinational helpers
  logic        flush;
  logic        resp_ok;
  logic        mem_ready_go;
  logic        leaving;
  logic        is_load;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] final_result;
  logic        fwd_we;
  logic        fwd_block;

  // Handshake and readiness terms.
  always_comb begin
    flush        = wb_ex | ertn_flush;
    // A response arriving while a stale one is owed belongs to the killed
    // instruction, so it never counts for the current one.
    resp_ok      = data_sram_data_ok & ~discard_q;
    mem_ready_go = ~bus_q.mem_req | buf_valid_q | resp_ok;
    mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
    mem_wb_valid = mem_valid_q & mem_ready_go;
    leaving      = mem_wb_valid & wb_allowin;
    is_load      = (bus_q.ld_op != '0);
  end

  // Next-state for valid bit and the latched instruction bus.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
    end
    if (ex_mem_valid & mem_allowin) begin
      bus_d = ex_mem_bus;
    end
  end

  // Next-state for the response buffer used while WB back-pressures.
  always_comb begin
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (flush | leaving) begin
      buf_valid_d = 1'b0;
    end else if (resp_ok & mem_valid_q & bus_q.mem_req & ~wb_allowin & ~buf_valid_q) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // Next-state for the stale-response marker.
  always_comb begin
    discard_d = discard_q;
    // A response that lands in the flush cycle itself is consumed here, so
    // only a still-outstanding request leaves a stale response behind.
    if (flush & mem_valid_q & bus_q.mem_req & ~buf_valid_q & ~data_sram_data_ok) begin
      discard_d = 1'b1;
    end else if (data_sram_data_ok) begin
      discard_d = 1'b0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the data registers (bus and response buffer) are reset too,
      // because the outputs must read as all-zero straight out of reset.
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      rdata_buf_q <= '0;
      buf_valid_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values, independent of statement order.
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
      buf_valid_q <= buf_valid_d;
      discard_q   <= discard_d;
    end
  end

  // Load alignment and extension.
  always_comb begin
    ld_word = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    unique case (bus_q.alu_result[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = bus_q.alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    if (bus_q.ld_op.lb) begin
      ld_ext = {{24{ld_byte[7]}}, ld_byte};
    end else if (bus_q.ld_op.lh) begin
      ld_ext = {{16{ld_half[15]}}, ld_half};
    end else if (bus_q.ld_op.lbu) begin
      ld_ext = {24'd0, ld_byte};
    end else if (bus_q.ld_op.lhu) begin
      ld_ext = {16'd0, ld_half};
    end else begin
      ld_ext = ld_word;
    end
    final_result = is_load ? ld_ext : bus_q.alu_result;
  end

  // Forwarding to ID, flush hint to EX, and the WB bus.
  always_comb begin
    // Excepting instructions never write the register file, so nothing to forward.
    fwd_we         = mem_valid_q & bus_q.gr_we & ~bus_q.ex_id;
    // A load without its data yet cannot forward; ID must stall on a match.
    fwd_block      = fwd_we & is_load & ~mem_ready_go;
    mem_id_bus     = {fwd_we, fwd_block, bus_q.dest, final_result};
    mem_flush_hint = mem_valid_q & (bus_q.ex_id | bus_q.ertn);
    mem_wb_bus     = {bus_q.gr_we, bus_q.pc, bus_q.inst, final_result,
                      bus_q.dest, bus_q.csr_we, bus_q.csr_re, bus_q.csr_num,
                      bus_q.csr_wmask, bus_q.csr_wvalue, bus_q.ertn,
                      bus_q.syscall_ex, bus_q.wrong_addr, bus_q.ex_id,
                      bus_q.esubcode, bus_q.ecode};
  end

endmodule
